// File: rtl/regex_stim_tx.sv
// Symbol-stream transmitter for the sequential regex recognizer: streams a packed
// 2-bit symbol string, holds the recognizer in reset between strings, and reports verdicts.
module regex_stim_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [2*MAX_LEN-1:0] str_in,
    input  logic [LEN_W-1:0]     len_in,
    output logic                 busy,
    output logic                 rx_res_n,
    output logic [1:0]           symbol_out,
    output logic                 last_symbol,
    output logic                 sym_valid,
    input  logic                 done_in,
    input  logic                 result_in,
    output logic                 match,
    output logic                 match_valid,
    output logic                 err,
    output logic [CNT_W-1:0]     tx_count,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     err_count
);

    localparam int TOUT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    function automatic logic [1:0] sym_at(input logic [2*MAX_LEN-1:0] s,
                                          input logic [LEN_W-1:0]     i);
        logic [2*MAX_LEN-1:0] sh;
        sh = s >> {i, 1'b0};
        return sh[1:0];
    endfunction

    state_t               state_r, state_s;
    logic [2*MAX_LEN-1:0] str_r, str_s;
    logic [LEN_W-1:0]     len_r, len_s;
    logic [LEN_W-1:0]     idx_r, idx_s;
    logic [TOUT_W-1:0]    tout_r, tout_s;
    logic                 busy_r, busy_s;
    logic                 rx_res_n_r, rx_res_n_s;
    logic [1:0]           symbol_r, symbol_s;
    logic                 last_r, last_s;
    logic                 sym_valid_r, sym_valid_s;
    logic                 match_r, match_s;
    logic                 match_valid_r, match_valid_s;
    logic                 err_r, err_s;
    logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_s;
    logic [CNT_W-1:0]     pass_cnt_r, pass_cnt_s;
    logic [CNT_W-1:0]     err_cnt_r, err_cnt_s;
    logic                 len_ok_s;
    logic [LEN_W-1:0]     idx_next_s;
    logic [LEN_W-1:0]     len_last_s;

    // Next-state and next-output computation for every registered signal.
    always_comb begin
        state_s       = state_r;
        str_s         = str_r;
        len_s         = len_r;
        idx_s         = idx_r;
        tout_s        = tout_r;
        busy_s        = busy_r;
        rx_res_n_s    = rx_res_n_r;
        symbol_s      = symbol_r;
        last_s        = last_r;
        sym_valid_s   = sym_valid_r;
        match_s       = match_r;
        match_valid_s = 1'b0;
        err_s         = 1'b0;
        tx_cnt_s      = tx_cnt_r;
        pass_cnt_s    = pass_cnt_r;
        err_cnt_s     = err_cnt_r;
        len_ok_s      = (len_in != {LEN_W{1'b0}}) && (len_in <= LEN_W'(MAX_LEN));
        idx_next_s    = idx_r + LEN_W'(1);
        len_last_s    = len_r - LEN_W'(1);

        case (state_r)
            ST_IDLE: begin
                rx_res_n_s  = 1'b0;
                sym_valid_s = 1'b0;
                symbol_s    = 2'b00;
                last_s      = 1'b0;
                busy_s      = 1'b0;
                if (start) begin
                    if (len_ok_s) begin
                        state_s     = ST_STREAM;
                        str_s       = str_in;
                        len_s       = len_in;
                        idx_s       = {LEN_W{1'b0}};
                        tx_cnt_s    = tx_cnt_r + CNT_W'(1);
                        busy_s      = 1'b1;
                        rx_res_n_s  = 1'b1;
                        symbol_s    = str_in[1:0];
                        sym_valid_s = 1'b1;
                        last_s      = (len_in == LEN_W'(1));
                    end else begin
                        err_s     = 1'b1;
                        err_cnt_s = err_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // idx_r is the index of the symbol currently on symbol_out
                if (idx_r == len_last_s) begin
                    state_s     = ST_WAIT;
                    symbol_s    = 2'b00;
                    sym_valid_s = 1'b0;
                    last_s      = 1'b0;
                    tout_s      = {TOUT_W{1'b0}};
                end else begin
                    idx_s    = idx_next_s;
                    symbol_s = sym_at(str_r, idx_next_s);
                    last_s   = (idx_next_s == len_last_s);
                end
            end
            ST_WAIT: begin
                if (done_in) begin
                    state_s       = ST_IDLE;
                    match_s       = result_in;
                    match_valid_s = 1'b1;
                    pass_cnt_s    = result_in ? pass_cnt_r + CNT_W'(1) : pass_cnt_r;
                    rx_res_n_s    = 1'b0;
                    busy_s        = 1'b0;
                end else if (tout_r == TOUT_W'(TIMEOUT - 1)) begin
                    state_s    = ST_IDLE;
                    match_s    = 1'b0;
                    err_s      = 1'b1;
                    err_cnt_s  = err_cnt_r + CNT_W'(1);
                    rx_res_n_s = 1'b0;
                    busy_s     = 1'b0;
                end else begin
                    tout_s = tout_r + TOUT_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                busy_s      = 1'b0;
                rx_res_n_s  = 1'b0;
                sym_valid_s = 1'b0;
                symbol_s    = 2'b00;
                last_s      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r       <= ST_IDLE;
            str_r         <= {(2*MAX_LEN){1'b0}};
            len_r         <= {LEN_W{1'b0}};
            idx_r         <= {LEN_W{1'b0}};
            tout_r        <= {TOUT_W{1'b0}};
            busy_r        <= 1'b0;
            rx_res_n_r    <= 1'b0;
            symbol_r      <= 2'b00;
            last_r        <= 1'b0;
            sym_valid_r   <= 1'b0;
            match_r       <= 1'b0;
            match_valid_r <= 1'b0;
            err_r         <= 1'b0;
            tx_cnt_r      <= {CNT_W{1'b0}};
            pass_cnt_r    <= {CNT_W{1'b0}};
            err_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            str_r         <= str_s;
            len_r         <= len_s;
            idx_r         <= idx_s;
            tout_r        <= tout_s;
            busy_r        <= busy_s;
            rx_res_n_r    <= rx_res_n_s;
            symbol_r      <= symbol_s;
            last_r        <= last_s;
            sym_valid_r   <= sym_valid_s;
            match_r       <= match_s;
            match_valid_r <= match_valid_s;
            err_r         <= err_s;
            tx_cnt_r      <= tx_cnt_s;
            pass_cnt_r    <= pass_cnt_s;
            err_cnt_r     <= err_cnt_s;
        end
    end

    assign busy        = busy_r;
    assign rx_res_n    = rx_res_n_r;
    assign symbol_out  = symbol_r;
    assign last_symbol = last_r;
    assign sym_valid   = sym_valid_r;
    assign match       = match_r;
    assign match_valid = match_valid_r;
    assign err         = err_r;
    assign tx_count    = tx_cnt_r;
    assign pass_count  = pass_cnt_r;
    assign err_count   = err_cnt_r;

endmodule
